// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//  Shared definitions for the UART receive path (and the future transmitter).
//  Holds the frame width, the default clock/baud pair and the receiver state
//  encoding.
//  Optional feature macro: UART_RX_PARITY_EN adds the RX_PARITY state.
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;
`endif

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
//  Generic two-flop synchroniser for a single asynchronous level.
//  Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous active-high reset, both flops load RST_VAL
//   d    in  1  asynchronous input
//   q    out 1  synchronised output (second flop)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // The first flop may go metastable; only the second one is ever used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  8N1 UART receiver, LSB first. Synchronises the RX pin, qualifies the start
//  bit at its middle, samples each data bit at mid-bit and reports one byte
//  per good frame as a single-cycle strobe.
//  Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   rx           in   1  serial line, idle high, asynchronous to clk
//   rx_data      out  8  last correctly framed byte
//   new_rx_data  out  1  one-cycle strobe, rx_data valid in the same cycle
//   frame_err    out  1  one-cycle strobe, stop bit sampled low
//   parity_err   out  1  one-cycle strobe, even parity mismatch
//                        (only with UART_RX_PARITY_EN)
//   rx_busy      out  1  high whenever the receiver is not idle
//  Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int BAUD        = DEFAULT_BAUD,
    parameter int CLK_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 new_rx_data,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 rx_busy
);

    // CLK_PER_BIT is expected to be at least 8 so the half-bit point exists.
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   new_rx_data_q, new_rx_data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    sync2 #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            sh_q          <= '0;
            rx_data_q     <= '0;
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
            armed_q       <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            sh_q          <= sh_d;
            rx_data_q     <= rx_data_d;
            new_rx_data_q <= new_rx_data_d;
            frame_err_q   <= frame_err_d;
            armed_q       <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q         <= par_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // The bit-time counter free-runs inside a state and is cleared on every
    // sample point and state change, so each sample lands one bit time after
    // the previous one.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_d         = bit_q;
        sh_d          = sh_q;
        rx_data_d     = rx_data_q;
        armed_d       = armed_q;
        new_rx_data_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d         = par_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // After a bad stop bit the line may sit low (break); that
                // level must not look like a new start bit until it has
                // returned high at least once.
                if (!armed_q) begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end
                end else if (!rx_s) begin
                    state_d = RX_START;
                end
            end

            RX_START: begin
                // Recheck at the middle of the start bit to reject glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end
            end

            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = RX_STOP;
                end
            end
`endif

            RX_STOP: begin
                // Leaving at mid-stop-bit gives half a bit of slack so a
                // following start bit with no idle gap is still caught.
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (^{sh_q, par_q}) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else begin
                        rx_data_d     = sh_q;
                        new_rx_data_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data     = rx_data_q;
    assign new_rx_data = new_rx_data_q;
    assign frame_err   = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif
    assign rx_busy     = (state_q != RX_IDLE);

endmodule
